sram_burst_ctrl: RTL and testbench

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

---
 rtl/sram_burst_ctrl.sv | 137 +++++++++++++
 tb/tb_sram_burst_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_ctrl.sv
// Burst controller for an asynchronous-style SRAM. It issues a run of consecutive
// word reads or writes, holding each strobe for ACCESS_CYC cycles with a turnaround gap between words.
//
//   state  | meaning
//   IDLE   | waiting for start with a non-zero length
//   ACCESS | one strobe held for ACCESS_CYC cycles on the current word
//   GAP    | both strobes low for one cycle; advance to the next word or finish
//   DONE   | io_done pulse, then back to IDLE
module sram_burst_ctrl #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 24,
   parameter int LEN_W      = 5,
   parameter int ACCESS_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              writemode,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [LEN_W-1:0]  i_len,
   input  logic [DATA_W-1:0] i_w_data,
   output logic              w_take,
   output logic [DATA_W-1:0] o_r_data,
   output logic              r_valid,
   output logic              busy,
   output logic              io_done,
   output logic              read_enable,
   output logic              write_enable,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] w_data,
   input  logic [DATA_W-1:0] r_data
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  left_q, left_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         left_q   <= '0;
         mode_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         mode_q   <= mode_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      mode_d   = mode_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && (i_len != '0)) begin
               mode_d  = writemode;
               addr_d  = i_address;
               left_d  = i_len;
               wdata_d = i_w_data;
               cnt_d   = ACC_LOAD;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // cnt_q is the number of strobe cycles still to go after this one
            if (cnt_q == '0) begin
               left_d = left_q - LEN_W'(1);
               if (!mode_q) begin
                  rdata_d  = r_data;
                  rvalid_d = 1'b1;
               end
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (left_q == '0) begin
               state_d = ST_DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               wdata_d = i_w_data;
               cnt_d   = ACC_LOAD;
               state_d = ST_ACCESS;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy         = (state_q != ST_IDLE);
   assign io_done      = (state_q == ST_DONE);
   assign read_enable  = (state_q == ST_ACCESS) && !mode_q;
   assign write_enable = (state_q == ST_ACCESS) && mode_q;
   assign w_take       = (state_q == ST_ACCESS) && mode_q && (cnt_q == ACC_LOAD);
   assign address      = addr_q;
   assign w_data       = wdata_q;
   assign o_r_data     = rdata_q;
   assign r_valid      = rvalid_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl: SRAM model on the main instance plus two
// extra instances at ACCESS_CYC=1 and 4 for the latency sweep.
module tb_sram_burst_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, writemode;
   logic [15:0] i_address;
   logic [4:0]  i_len;
   logic [23:0] i_w_data;
   logic        w_take, r_valid, busy, io_done, read_enable, write_enable;
   logic [23:0] o_r_data, w_data, r_data;
   logic [15:0] address;

   logic        start_s;
   logic        w_take1, r_valid1, busy1, io_done1, re1, we1;
   logic        w_take4, r_valid4, busy4, io_done4, re4, we4;
   logic [23:0] o_r_data1, w_data1, r_data1, o_r_data4, w_data4, r_data4;
   logic [15:0] address1, address4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_burst_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .writemode(writemode),
      .i_address(i_address), .i_len(i_len), .i_w_data(i_w_data),
      .w_take(w_take), .o_r_data(o_r_data), .r_valid(r_valid), .busy(busy),
      .io_done(io_done), .read_enable(read_enable), .write_enable(write_enable),
      .address(address), .w_data(w_data), .r_data(r_data)
   );

   sram_burst_ctrl #(.ACCESS_CYC(1)) dut1 (
      .clk(clk), .rst(rst), .start(start_s), .writemode(1'b0),
      .i_address(16'h0005), .i_len(5'd1), .i_w_data(24'h0),
      .w_take(w_take1), .o_r_data(o_r_data1), .r_valid(r_valid1), .busy(busy1),
      .io_done(io_done1), .read_enable(re1), .write_enable(we1),
      .address(address1), .w_data(w_data1), .r_data(r_data1)
   );

   sram_burst_ctrl #(.ACCESS_CYC(4)) dut4 (
      .clk(clk), .rst(rst), .start(start_s), .writemode(1'b0),
      .i_address(16'h0005), .i_len(5'd1), .i_w_data(24'h0),
      .w_take(w_take4), .o_r_data(o_r_data4), .r_valid(r_valid4), .busy(busy4),
      .io_done(io_done4), .read_enable(re4), .write_enable(we4),
      .address(address4), .w_data(w_data4), .r_data(r_data4)
   );

   // SRAM model: a write commits only once the strobe has been held a full ACCESS_CYC=2 cycles
   logic [23:0] mem [0:65535] = '{default: 24'h0};
   int          we_run = 0;
   logic [15:0] we_a;
   logic [23:0] we_dat;

   always @(posedge clk) begin
      if (write_enable) begin
         we_run <= we_run + 1;
         we_a   <= address;
         we_dat <= w_data;
      end else begin
         if (we_run == 2) mem[we_a] <= we_dat;
         we_run <= 0;
      end
   end

   assign r_data  = read_enable ? mem[address] : 24'h0;
   assign r_data1 = re1 ? 24'h00C0DE : 24'h0;
   assign r_data4 = re4 ? 24'hBEEF01 : 24'h0;

   // observations collected by burst()
   logic [23:0] wwords [$];
   logic [23:0] rdq [$];
   logic [15:0] waddr [$];
   int done_cyc, n_done, n_wtake, n_re, n_busy, both_hi;

   task automatic burst(input logic wm, input logic [15:0] base, input logic [4:0] len,
                        input int ncyc, input int inj_cyc);
      int wdi = 0;
      rdq.delete();
      waddr.delete();
      done_cyc = 0; n_done = 0; n_wtake = 0; n_re = 0; n_busy = 0; both_hi = 0;
      i_w_data  = (wwords.size() > 0) ? wwords[0] : 24'h0;
      writemode = wm;
      i_address = base;
      i_len     = len;
      start     = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (c == inj_cyc) begin
            start     = 1'b1;
            i_len     = 5'd5;
            i_address = 16'h0040;
         end
         if (io_done) begin
            n_done++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (w_take) begin
            n_wtake++;
            wdi++;
            if (wdi < wwords.size()) i_w_data = wwords[wdi];
         end
         if (r_valid) rdq.push_back(o_r_data);
         if (write_enable) waddr.push_back(address);
         if (read_enable) n_re++;
         if (busy) n_busy++;
         if (read_enable && write_enable) both_hi++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if ({busy, io_done, r_valid, w_take, read_enable, write_enable} !== 6'b0) begin
         n_err++; $display("FAIL rst_ctrl: got %b expected 000000",
                           {busy, io_done, r_valid, w_take, read_enable, write_enable});
      end
      n_vec++; if (address !== 16'h0) begin
         n_err++; $display("FAIL rst_address: got %h expected 0000", address);
      end
      n_vec++; if (w_data !== 24'h0 || o_r_data !== 24'h0) begin
         n_err++; $display("FAIL rst_data: got w_data %h o_r_data %h expected 0", w_data, o_r_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_write();
      logic [15:0] exp_a [6] = '{16'h0010, 16'h0010, 16'h0011, 16'h0011, 16'h0012, 16'h0012};
      wwords = '{24'hA1B2C3, 24'hD4E5F6, 24'h010203};
      burst(1'b1, 16'h0010, 5'd3, 14, 0);
      n_vec++; if (done_cyc !== 10 || n_done !== 1) begin
         n_err++; $display("FAIL wr_done: got cycle %0d count %0d expected cycle 10 count 1", done_cyc, n_done);
      end
      n_vec++; if (n_wtake !== 3) begin
         n_err++; $display("FAIL wr_take: got %0d expected 3", n_wtake);
      end
      n_vec++; if (waddr.size() !== 6 || n_re !== 0) begin
         n_err++; $display("FAIL wr_strobes: got we %0d re %0d expected we 6 re 0", waddr.size(), n_re);
      end
      for (int i = 0; i < 6 && i < waddr.size(); i++) begin
         n_vec++; if (waddr[i] !== exp_a[i]) begin
            n_err++; $display("FAIL wr_addr[%0d]: got %h expected %h", i, waddr[i], exp_a[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (mem[16'h0010 + 16'(i)] !== wwords[i]) begin
            n_err++; $display("FAIL wr_mem[%0d]: got %h expected %h", i, mem[16'h0010 + 16'(i)], wwords[i]);
         end
      end
      n_vec++; if (both_hi !== 0) begin
         n_err++; $display("FAIL wr_both_en: got %0d cycles expected 0", both_hi);
      end
   endtask

   task automatic test_start_busy();
      wwords = '{24'h0A0A0A, 24'h0B0B0B};
      burst(1'b1, 16'h0020, 5'd2, 12, 3);
      n_vec++; if (done_cyc !== 7 || n_done !== 1) begin
         n_err++; $display("FAIL busy_done: got cycle %0d count %0d expected cycle 7 count 1", done_cyc, n_done);
      end
      n_vec++; if (waddr.size() !== 4) begin
         n_err++; $display("FAIL busy_we_cycles: got %0d expected 4", waddr.size());
      end
      n_vec++; if (mem[16'h0020] !== 24'h0A0A0A || mem[16'h0021] !== 24'h0B0B0B) begin
         n_err++; $display("FAIL busy_mem: got %h %h expected 0a0a0a 0b0b0b", mem[16'h0020], mem[16'h0021]);
      end
      n_vec++; if (mem[16'h0040] !== 24'h0 || busy !== 1'b0) begin
         n_err++; $display("FAIL busy_ignored: got mem40 %h busy %b expected 0 0", mem[16'h0040], busy);
      end
   endtask

   task automatic test_read();
      logic [23:0] exp_r [3] = '{24'hA1B2C3, 24'hD4E5F6, 24'h010203};
      wwords.delete();
      burst(1'b0, 16'h0010, 5'd3, 11, 0);
      n_vec++; if (done_cyc !== 10 || n_done !== 1) begin
         n_err++; $display("FAIL rd_done: got cycle %0d count %0d expected cycle 10 count 1", done_cyc, n_done);
      end
      n_vec++; if (rdq.size() !== 3 || n_wtake !== 0 || waddr.size() !== 0 || n_re !== 6) begin
         n_err++; $display("FAIL rd_pulses: got rvalid %0d wtake %0d we %0d re %0d expected 3 0 0 6",
                           rdq.size(), n_wtake, waddr.size(), n_re);
      end
      for (int i = 0; i < 3 && i < rdq.size(); i++) begin
         n_vec++; if (rdq[i] !== exp_r[i]) begin
            n_err++; $display("FAIL rd_data[%0d]: got %h expected %h", i, rdq[i], exp_r[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      burst(1'b0, 16'h0020, 5'd2, 9, 0);
      n_vec++; if (done_cyc !== 7 || rdq.size() !== 2) begin
         n_err++; $display("FAIL b2b_done: got cycle %0d rvalid %0d expected cycle 7 rvalid 2", done_cyc, rdq.size());
      end
      n_vec++; if (rdq.size() == 2 && (rdq[0] !== 24'h0A0A0A || rdq[1] !== 24'h0B0B0B)) begin
         n_err++; $display("FAIL b2b_data: got %h %h expected 0a0a0a 0b0b0b", rdq[0], rdq[1]);
      end
   endtask

   task automatic test_wrap();
      wwords = '{24'h111111, 24'h222222};
      burst(1'b1, 16'hFFFF, 5'd2, 9, 0);
      n_vec++; if (done_cyc !== 7) begin
         n_err++; $display("FAIL wrap_done: got cycle %0d expected 7", done_cyc);
      end
      n_vec++; if (waddr.size() !== 4 || waddr[0] !== 16'hFFFF || waddr[3] !== 16'h0000) begin
         n_err++; $display("FAIL wrap_addr: got %0d strobes first %h last %h expected 4 ffff 0000",
                           waddr.size(), (waddr.size() > 0) ? waddr[0] : 16'h0,
                           (waddr.size() > 3) ? waddr[3] : 16'h0);
      end
      n_vec++; if (mem[16'hFFFF] !== 24'h111111 || mem[16'h0000] !== 24'h222222) begin
         n_err++; $display("FAIL wrap_mem: got %h %h expected 111111 222222", mem[16'hFFFF], mem[16'h0000]);
      end
   endtask

   task automatic test_len0();
      wwords = '{24'h555555};
      burst(1'b1, 16'h0050, 5'd0, 10, 0);
      n_vec++; if (n_done !== 0 || waddr.size() !== 0 || n_re !== 0 || n_busy !== 0) begin
         n_err++; $display("FAIL len0: got done %0d we %0d re %0d busy %0d expected all 0",
                           n_done, waddr.size(), n_re, n_busy);
      end
   endtask

   task automatic test_rst_mid();
      int bad = 0;
      writemode = 1'b1; i_address = 16'h0030; i_len = 5'd3; i_w_data = 24'h777777;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_vec++; if (write_enable !== 1'b1) begin
         n_err++; $display("FAIL rstmid_pre: got write_enable %b expected 1", write_enable);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++; if ({busy, read_enable, write_enable, io_done} !== 4'b0) begin
         n_err++; $display("FAIL rstmid_ctrl: got %b expected 0000", {busy, read_enable, write_enable, io_done});
      end
      n_vec++; if (address !== 16'h0) begin
         n_err++; $display("FAIL rstmid_address: got %h expected 0000", address);
      end
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (io_done || write_enable || read_enable || busy) bad++;
      end
      n_vec++; if (bad !== 0) begin
         n_err++; $display("FAIL rstmid_after: got %0d active cycles expected 0", bad);
      end
      n_vec++; if (mem[16'h0030] !== 24'h0) begin
         n_err++; $display("FAIL rstmid_mem: got %h expected 000000", mem[16'h0030]);
      end
   endtask

   task automatic test_sweep();
      int d1 = 0, d4 = 0, v1 = 0, v4 = 0;
      start_s = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
         start_s = 1'b0;
         if (io_done1 && d1 == 0) d1 = c;
         if (io_done4 && d4 == 0) d4 = c;
         if (r_valid1 && v1 == 0) v1 = c;
         if (r_valid4 && v4 == 0) v4 = c;
      end
      n_vec++; if (d1 !== 3) begin
         n_err++; $display("FAIL sweep1_done: got cycle %0d expected 3", d1);
      end
      n_vec++; if (d4 !== 6) begin
         n_err++; $display("FAIL sweep4_done: got cycle %0d expected 6", d4);
      end
      n_vec++; if (v1 !== 2 || o_r_data1 !== 24'h00C0DE) begin
         n_err++; $display("FAIL sweep1_read: got cycle %0d data %h expected 2 00c0de", v1, o_r_data1);
      end
      n_vec++; if (v4 !== 5 || o_r_data4 !== 24'hBEEF01) begin
         n_err++; $display("FAIL sweep4_read: got cycle %0d data %h expected 5 beef01", v4, o_r_data4);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_s = 1'b0; writemode = 1'b0;
      i_address = 16'h0; i_len = 5'd0; i_w_data = 24'h0;
      test_reset();
      test_write();
      test_start_busy();
      test_read();
      test_back_to_back();
      test_wrap();
      test_len0();
      test_rst_mid();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
